// File: rtl/fifo_pkg.sv
// Shared types and Gray-code helpers for the async FIFO pointer blocks.
package fifo_pkg;

   localparam int ADDR_SIZE_DEF = 4;
   localparam int PTR_W_DEF     = ADDR_SIZE_DEF + 1;

   typedef logic [PTR_W_DEF-1:0] ptr_t;

   // Inputs are zero-extended into 32 bits; width masks the result back down.
   function automatic logic [31:0] bin2gray(input logic [31:0] bin, input int width);
      logic [31:0] mask;
      mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
      return (bin ^ (bin >> 1)) & mask;
   endfunction

   function automatic logic [31:0] gray2bin(input logic [31:0] gray, input int width);
      logic [31:0] bin;
      logic [31:0] mask;
      mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
      bin  = gray & mask;
      for (int i = 30; i >= 0; i--) begin
         bin[i] = bin[i] ^ bin[i+1];
      end
      return bin & mask;
   endfunction

endpackage

// File: rtl/fifo_wptr_full_gray2bin_conv.sv
// Combinational Gray-to-binary converter; each binary bit is the XOR of all
// Gray bits at or above it. Shared with the read-side empty block.
module gray2bin_conv #(
   parameter int W = 5
) (
   input  logic [W-1:0] gray,
   output logic [W-1:0] bin
);

   for (genvar i = 0; i < W; i++) begin : g_bit
      assign bin[i] = ^gray[W-1:i];
   end

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-domain pointer/status stage of the async FIFO: write pointers, RAM
// write port, full / almost-full / level. Optional macro: FIFO_WOVF_STICKY_EN.
module fifo_wptr_full
   import fifo_pkg::*;
#(
   parameter int ADDR_SIZE    = ADDR_SIZE_DEF,
   parameter int AFULL_THRESH = 12
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 winc,
`ifdef FIFO_WOVF_STICKY_EN
   input  logic                 wovf_clr,
`endif
   input  logic [ADDR_SIZE:0]   wq2_rptr,
   output logic                 wen,
   output logic [ADDR_SIZE-1:0] waddr,
   output logic [ADDR_SIZE:0]   wptr,
   output logic                 wfull,
   output logic                 walmost_full,
   output logic [ADDR_SIZE:0]   wlevel
`ifdef FIFO_WOVF_STICKY_EN
   ,
   output logic                 wovf
`endif
);

   localparam int PW = ADDR_SIZE + 1;
   localparam logic [PW-1:0] AFULL_LVL = PW'(AFULL_THRESH);

   logic [PW-1:0] wbin_r;
   logic [PW-1:0] wbin_next_s;
   logic [PW-1:0] wgray_next_s;
   logic [PW-1:0] rbin_s;
   logic [PW-1:0] level_next_s;
   logic [PW-1:0] full_ptr_s;
   logic          wfull_next_s;
   logic          wafull_next_s;

   gray2bin_conv #(.W(PW)) u_rptr_conv (
      .gray (wq2_rptr),
      .bin  (rbin_s)
   );

   assign wen   = winc & ~wfull;
   assign waddr = wbin_r[ADDR_SIZE-1:0];

   // Full means the write pointer sits exactly one lap ahead of the read
   // pointer: in Gray that is the read pointer with its top two bits flipped.
   always_comb begin
      wbin_next_s   = wbin_r + {{ADDR_SIZE{1'b0}}, wen};
      wgray_next_s  = PW'(bin2gray(32'(wbin_next_s), PW));
      full_ptr_s    = {~wq2_rptr[ADDR_SIZE:ADDR_SIZE-1], wq2_rptr[ADDR_SIZE-2:0]};
      level_next_s  = wbin_next_s - rbin_s;
      if (wgray_next_s == full_ptr_s) begin
         wfull_next_s = 1'b1;
      end else begin
         wfull_next_s = 1'b0;
      end
      if (level_next_s >= AFULL_LVL) begin
         wafull_next_s = 1'b1;
      end else begin
         wafull_next_s = 1'b0;
      end
   end

   // Pointer and status registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wbin_r       <= {PW{1'b0}};
         wptr         <= {PW{1'b0}};
         wfull        <= 1'b0;
         walmost_full <= 1'b0;
         wlevel       <= {PW{1'b0}};
      end else begin
         wbin_r       <= wbin_next_s;
         wptr         <= wgray_next_s;
         wfull        <= wfull_next_s;
         walmost_full <= wafull_next_s;
         wlevel       <= level_next_s;
      end
   end

`ifdef FIFO_WOVF_STICKY_EN
   // Sticky overflow: a dropped write wins over a same-cycle clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wovf <= 1'b0;
      end else if (winc && wfull) begin
         wovf <= 1'b1;
      end else if (wovf_clr) begin
         wovf <= 1'b0;
      end else begin
         wovf <= wovf;
      end
   end
`endif

endmodule
